// File: rtl/stage_buffer_pkg.sv
// Shared ex/mem payload layout: field widths, bit offsets and the default payload width.
package stage_buffer_pkg;

  localparam int RegAddrBus  = 5;
  localparam int RegBus      = 32;
  localparam int InstAddrBus = 32;
  localparam int AluOpBus    = 10;

  // Offsets from bit 0 upward; wd sits in the top bits.
  localparam int REG2_OFF     = 0;
  localparam int MEM_ADDR_OFF = REG2_OFF + RegBus;
  localparam int ALUOP_OFF    = MEM_ADDR_OFF + RegBus;
  localparam int PC_OFF       = ALUOP_OFF + AluOpBus;
  localparam int WDATA_OFF    = PC_OFF + InstAddrBus;
  localparam int WREG_OFF     = WDATA_OFF + RegBus;
  localparam int WD_OFF       = WREG_OFF + 1;
  localparam int DATA_W_DEF   = WD_OFF + RegAddrBus;

  typedef struct packed {
    logic [RegAddrBus-1:0]  wd;
    logic                   wreg;
    logic [RegBus-1:0]      wdata;
    logic [InstAddrBus-1:0] pc;
    logic [AluOpBus-1:0]    aluop;
    logic [RegBus-1:0]      mem_addr;
    logic [RegBus-1:0]      reg2;
  } ex_mem_t;

endpackage

// File: rtl/stage_buffer.sv
// Valid/ready pipeline register between pipeline stages with a saturating stall counter.
// STAGE_BUFFER_SKID_EN adds a second (skid) entry so in_ready is a pure register output.
module stage_buffer
  import stage_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

  // Counts every held-but-unconsumed cycle; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)                                         cnt_q <= '0;
    else if (out_valid && !out_ready && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

`ifdef STAGE_BUFFER_SKID_EN

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_nxt;
  logic              rdy_q;
  logic [DATA_W-1:0] skid_q;
  logic              ld_main_in, ld_main_skid, ld_skid;
  logic              in_fire, out_fire;

  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && rdy_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin state_nxt = ONE; ld_main_in = 1'b1; end
        ONE: begin
          if (in_fire && !out_fire)     begin state_nxt = TWO; ld_skid = 1'b1; end
          else if (in_fire && out_fire) ld_main_in = 1'b1;
          else if (out_fire)            state_nxt = EMPTY;
        end
        TWO: if (out_fire) begin state_nxt = ONE; ld_main_skid = 1'b1; end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b1;
      data_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != TWO);
      if (ld_main_in)        data_q <= in_data;
      else if (ld_main_skid) data_q <= skid_q;
      if (ld_skid)           skid_q <= in_data;
    end
  end

`else

  logic vld_q;

  assign out_valid = vld_q;
  assign in_ready  = !vld_q || out_ready;

  // Single entry: refills in the same cycle it drains, so streaming runs at full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (in_ready) begin
      vld_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

`endif

endmodule

// File: tb/tb_stage_buffer.sv
// Scoreboard bench for stage_buffer: directed streaming, backpressure, flush, reset and saturation cases.
module tb_stage_buffer;
  import stage_buffer_pkg::*;

  localparam int DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4;

  int pass_cnt = 0, total_cnt = 0;
  int in_cnt = 0, out_cnt = 0;
  bit seen_a5 = 1'b0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  stage_buffer #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .stall_cnt(stall_cnt));

  stage_buffer #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_ready(out_ready), .stall_cnt(stall_cnt4));

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor pops on each out transfer, then records accepted input for later comparison.
  always @(negedge clk) begin
    if (out_valid && out_data == DW'(8'hA5)) seen_a5 = 1'b1;
    if (!rst && !flush && out_valid && out_ready) begin
      out_cnt++;
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got %0h expected none", out_data);
      end else begin
        chk("sb_data", out_data, sb_q.pop_front());
      end
    end
    if (rst || flush) sb_q.delete();
    else if (in_valid && in_ready) begin
      sb_q.push_back(in_data);
      in_cnt++;
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(2);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // Backpressure and saturation: one entry held, consumer stalled for 20 cycles.
    in_valid = 1'b1; in_data = DW'(8'h11);
    step();
    in_valid = 1'b0;
    step(5);
    chk("bp_stall_cnt5", stall_cnt, 5);
    chk("bp_data_stable", out_data, DW'(8'h11));
`ifdef STAGE_BUFFER_SKID_EN
    chk("bp_in_ready_one", in_ready, 1);
    in_valid = 1'b1; in_data = DW'(8'h12);
    step();
    in_valid = 1'b0;
    chk("bp_in_ready_two", in_ready, 0);
    step(14);
`else
    chk("bp_in_ready", in_ready, 0);
    step(15);
`endif
    chk("bp_stall_cnt20", stall_cnt, 20);
    chk("sat_stall_cnt4", stall_cnt4, 15);
    chk("bp_data_stable2", out_data, DW'(8'h11));
    out_ready = 1'b1;
    step(4);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_stall_hold", stall_cnt, 20);
    rst = 1'b1; step(); rst = 1'b0;

    // Streaming 1..8 with one-cycle latency.
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      step();
      chk($sformatf("stream_data%0d", i), {out_valid, out_data}, {1'b1, DW'(i)});
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", out_valid, 0);
    chk("stream_stall_cnt", stall_cnt, 0);

    // Flush beats a same-cycle in-transfer and keeps stall_cnt.
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h05);
    step();
    flush = 1'b1; in_data = DW'(8'hA5);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_data_kept", out_data, DW'(8'h05));
    chk("flush_stall_cnt", stall_cnt, 1);
    out_ready = 1'b1;
    step(3);
    chk("flush_no_a5", seen_a5, 0);

    // Reset from a full buffer with stall_cnt=7, flush and input also active.
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h21);
    step();
    in_data = DW'(8'h22);
    step();
    in_valid = 1'b0;
    step(6);
    chk("pre_rst_stall_cnt", stall_cnt, 7);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = DW'(8'h33);
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    chk("rst2_in_ready", in_ready, 1);

    // Random handshakes: ordering is checked by the monitor.
    in_cnt = 0; out_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = DW'(32'h1000 + k);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && out_valid; t++) step();
    chk("rand_drained", out_valid, 0);
    chk("rand_count", out_cnt, in_cnt);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
